// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with OVERSAMPLE clocks per bit, mid-bit sampling,
// start-glitch rejection and a break state that swallows a held-low line.
module uart_rx_8n1 #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rxdone,
  output logic       framing_err,
  output logic       busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic [1:0]    sync;
  logic          rx_s;

  // Reset to idle-high so a line released from reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end
  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bidx        <= '0;
      shreg       <= '0;
      rxbyte      <= '0;
      rxdone      <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rxdone      <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        // Re-check the line half a bit in; a high here was only a glitch
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              bidx  <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bidx == 3'd7) state <= STOP;
            else              bidx  <= bidx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rx_s) begin
              rxbyte <= shreg;
              rxdone <= 1'b1;
              state  <= IDLE;
              busy   <= 1'b0;
            end else begin
              framing_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, clk cycles per bit; legal values are even integers >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port rxbyte  output  8  last correctly framed byte, held until the next one.
REQ-006 SHALL have port rxdone  output  1  one-cycle pulse when rxbyte updates.
REQ-007 SHALL have port framing_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-010 SHALL use states IDLE, START, DATA, STOP and BREAK, plus a bit-time counter cnt and a 3-bit index bidx.
REQ-011 IDLE: when rx_s==0, SHALL go to START with cnt=0.
REQ-012 START: SHALL increment cnt; at cnt==OVERSAMPLE/2-1, SHALL go to DATA with cnt=0, bidx=0 if rx_s==0, else return to IDLE with no pulse (glitch rejection).
REQ-013 DATA: SHALL increment cnt; at cnt==OVERSAMPLE-1, SHALL sample rx_s into a shift register LSB-first (shift right, insert at bit 7) and set cnt=0.
REQ-014 DATA: after the sample with bidx==7, SHALL go to STOP; otherwise it SHALL increment bidx.
REQ-015 STOP: at cnt==OVERSAMPLE-1, if rx_s==1, SHALL load rxbyte from the shift register, pulse rxdone, and go to IDLE.
REQ-016 STOP: at cnt==OVERSAMPLE-1, if rx_s==0, SHALL pulse framing_err, leave rxbyte unchanged, and go to BREAK.
REQ-017 BREAK: SHALL stay until rx_s==1, then go to IDLE; a held-low line SHALL NOT produce further pulses.
REQ-018 Latency: with rx low first captured at edge k, the rxdone edge SHALL be k+2+OVERSAMPLE/2+9*OVERSAMPLE (154 cycles for OVERSAMPLE=16).
REQ-019 Back-to-back frames: a start edge seen in the first IDLE cycle after a stop bit SHALL be accepted with no dead cycles beyond that single IDLE cycle.
REQ-020 rxdone and framing_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per event.
REQ-021 cnt width SHALL be $clog2(OVERSAMPLE); the counter SHALL never wrap past OVERSAMPLE-1.

Reset
REQ-022 With rst_n low at a clk edge, the block SHALL enter IDLE.
REQ-023 Reset values SHALL be: rxbyte=0, rxdone=0, framing_err=0, busy=0, cnt=0, bidx=0, shift register=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rxdone/framing_err pulse.
REQ-025 After reset, the first falling edge of rx SHALL be treated as a new start bit.

Verification
REQ-026 Byte 0xA5 at 16 clk/bit, stop high -> rxbyte=0xA5, rxdone pulse exactly 154 cycles after the start edge, busy low the next cycle.
REQ-027 Frames 0x00, 0xFF, 0x3C back-to-back with no idle gap -> three rxdone pulses, rxbyte showing 0x00, 0xFF, 0x3C in order.
REQ-028 rx low pulse of 4 cycles from idle -> return to IDLE, no rxdone, no framing_err, rxbyte unchanged.
REQ-029 Byte 0x55 with stop bit low and line then held low for 50 bit times -> one framing_err pulse, rxbyte unchanged, busy high until rx rises, then a following 0x81 received correctly.
REQ-030 rst_n pulsed low during bit 4 of 0x96 -> all outputs return to reset values, no pulses, next frame 0x69 received as 0x69.
REQ-031 OVERSAMPLE=4 with byte 0xC3 -> rxdone at k+2+2+36=k+40, rxbyte=0xC3.
